// File: rtl/execute_stage.sv
// RV32I Execute stage: operand forwarding, ALU, branch/jump resolution and
// the Execute-to-Memory pipeline register with stall and bubble support.
module execute_stage #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               EnM,
  input  logic               FlushM,
  input  logic               ValidE,
  input  logic               RegWriteE,
  input  logic               MemWriteE,
  input  logic               a_typeE,
  input  logic               JumpE,
  input  logic               JalrE,
  input  logic               BranchE,
  input  logic               ALUSrcE,
  input  logic [1:0]         ResultSrcE,
  input  logic [3:0]         ALUControlE,
  input  logic [2:0]         Funct3E,
  input  logic [D_WIDTH-1:0] RD1E,
  input  logic [D_WIDTH-1:0] RD2E,
  input  logic [D_WIDTH-1:0] ImmExtE,
  input  logic [D_WIDTH-1:0] PCE,
  input  logic [D_WIDTH-1:0] PCPlus4E,
  input  logic [A_WIDTH-1:0] RdE,
  input  logic [1:0]         ForwardAE,
  input  logic [1:0]         ForwardBE,
  input  logic [D_WIDTH-1:0] ResultW,
  output logic               PCSrcE,
  output logic [D_WIDTH-1:0] PCTargetE,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic               a_typeM,
  output logic               ValidM,
  output logic [1:0]         ResultSrcM,
  output logic [D_WIDTH-1:0] ALUResultM,
  output logic [D_WIDTH-1:0] WriteDataM,
  output logic [D_WIDTH-1:0] PCPlus4M,
  output logic [A_WIDTH-1:0] RdM
);

  localparam int unsigned SH_W = 5;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_SLL   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  logic               r_reg_write;
  logic               r_mem_write;
  logic               r_a_type;
  logic               r_valid;
  logic [1:0]         r_result_src;
  logic [D_WIDTH-1:0] r_alu_result;
  logic [D_WIDTH-1:0] r_write_data;
  logic [D_WIDTH-1:0] r_pc_plus4;
  logic [A_WIDTH-1:0] r_rd;

  logic [D_WIDTH-1:0] w_src_a;
  logic [D_WIDTH-1:0] w_write_data;
  logic [D_WIDTH-1:0] w_src_b;
  logic [SH_W-1:0]    w_shamt;
  logic [D_WIDTH-1:0] w_alu_result;
  logic               w_ab_lt;
  logic               w_ab_ltu;
  logic               w_ab_lt_b;
  logic               w_ab_ltu_b;
  logic               w_cond;
  logic [D_WIDTH-1:0] w_jalr_sum;

  // Operand forwarding; code 10 feeds back the previous instruction's result
  always_comb begin
    w_src_a = RD1E;
    case (ForwardAE)
      2'b01:   w_src_a = ResultW;
      2'b10:   w_src_a = r_alu_result;
      default: w_src_a = RD1E;
    endcase
    w_write_data = RD2E;
    case (ForwardBE)
      2'b01:   w_write_data = ResultW;
      2'b10:   w_write_data = r_alu_result;
      default: w_write_data = RD2E;
    endcase
  end

  assign w_src_b = ALUSrcE ? ImmExtE : w_write_data;
  assign w_shamt = w_src_b[SH_W-1:0];
  assign w_ab_lt  = $signed(w_src_a) < $signed(w_src_b);
  assign w_ab_ltu = w_src_a < w_src_b;

  always_comb begin
    w_alu_result = '0;
    case (ALUControlE)
      ALU_ADD:   w_alu_result = w_src_a + w_src_b;
      ALU_SUB:   w_alu_result = w_src_a - w_src_b;
      ALU_AND:   w_alu_result = w_src_a & w_src_b;
      ALU_OR:    w_alu_result = w_src_a | w_src_b;
      ALU_XOR:   w_alu_result = w_src_a ^ w_src_b;
      ALU_SLT:   w_alu_result = {{(D_WIDTH-1){1'b0}}, w_ab_lt};
      ALU_SLTU:  w_alu_result = {{(D_WIDTH-1){1'b0}}, w_ab_ltu};
      ALU_SLL:   w_alu_result = w_src_a << w_shamt;
      ALU_SRL:   w_alu_result = w_src_a >> w_shamt;
      ALU_SRA:   w_alu_result = $unsigned($signed(w_src_a) >>> w_shamt);
      ALU_PASSB: w_alu_result = w_src_b;
      default:   w_alu_result = '0;
    endcase
  end

  // Branches always compare the register operands, never the immediate
  assign w_ab_lt_b  = $signed(w_src_a) < $signed(w_write_data);
  assign w_ab_ltu_b = w_src_a < w_write_data;

  always_comb begin
    w_cond = 1'b0;
    case (Funct3E)
      3'b000:  w_cond = (w_src_a == w_write_data);
      3'b001:  w_cond = (w_src_a != w_write_data);
      3'b100:  w_cond = w_ab_lt_b;
      3'b101:  w_cond = ~w_ab_lt_b;
      3'b110:  w_cond = w_ab_ltu_b;
      3'b111:  w_cond = ~w_ab_ltu_b;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_jalr_sum = w_src_a + ImmExtE;
  assign PCTargetE  = JalrE ? {w_jalr_sum[D_WIDTH-1:1], 1'b0} : (PCE + ImmExtE);
  assign PCSrcE     = ValidE & (JumpE | (BranchE & w_cond));

  // E/M pipeline register: reset and flush both produce a bubble
  always_ff @(posedge clk) begin
    if (!rst_n || FlushM) begin
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_a_type     <= 1'b0;
      r_valid      <= 1'b0;
      r_result_src <= '0;
      r_alu_result <= '0;
      r_write_data <= '0;
      r_pc_plus4   <= '0;
      r_rd         <= '0;
    end else if (EnM) begin
      r_reg_write  <= RegWriteE & ValidE;
      r_mem_write  <= MemWriteE & ValidE;
      r_a_type     <= a_typeE & ValidE;
      r_valid      <= ValidE;
      r_result_src <= ValidE ? ResultSrcE : 2'b00;
      r_alu_result <= w_alu_result;
      r_write_data <= w_write_data;
      r_pc_plus4   <= PCPlus4E;
      r_rd         <= RdE;
    end
  end

  assign RegWriteM  = r_reg_write;
  assign MemWriteM  = r_mem_write;
  assign a_typeM    = r_a_type;
  assign ValidM     = r_valid;
  assign ResultSrcM = r_result_src;
  assign ALUResultM = r_alu_result;
  assign WriteDataM = r_write_data;
  assign PCPlus4M   = r_pc_plus4;
  assign RdM        = r_rd;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed expected values.
module tb_execute_stage;

  logic        clk;
  logic        rst_n;
  logic        EnM, FlushM, ValidE;
  logic        RegWriteE, MemWriteE, a_typeE, JumpE, JalrE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, a_typeM, ValidM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  int n_cmp = 0;
  int n_err = 0;

  execute_stage #(.D_WIDTH(32), .A_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .EnM(EnM), .FlushM(FlushM), .ValidE(ValidE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .a_typeE(a_typeE),
    .JumpE(JumpE), .JalrE(JalrE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .Funct3E(Funct3E),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .a_typeM(a_typeM), .ValidM(ValidM),
    .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    EnM = 1'b1; FlushM = 1'b0; ValidE = 1'b1;
    RegWriteE = 1'b0; MemWriteE = 1'b0; a_typeE = 1'b0;
    JumpE = 1'b0; JalrE = 1'b0; BranchE = 1'b0; ALUSrcE = 1'b0;
    ResultSrcE = 2'b00; ALUControlE = 4'b0000; Funct3E = 3'b000;
    RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = '0; PCPlus4E = '0;
    RdE = '0; ForwardAE = 2'b00; ForwardBE = 2'b00; ResultW = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one ALU op with an immediate second operand and advance one edge
  task automatic alu_imm(input logic [3:0] op, input logic [31:0] a, input logic [31:0] imm);
    ALUControlE = op; RD1E = a; ImmExtE = imm; ALUSrcE = 1'b1;
    tick();
  endtask

  initial begin
    clk = 1'b0;
    clr();
    // Reset held for two edges while a live ADD is presented
    rst_n = 1'b0;
    RD1E = 32'd5; ImmExtE = 32'd7; ALUSrcE = 1'b1; RegWriteE = 1'b1;
    tick();
    chk("rst_alu", ALUResultM, 32'h0);
    chk("rst_valid", 32'(ValidM), 32'h0);
    tick();
    chk("rst_regwrite", 32'(RegWriteM), 32'h0);
    chk("rst_pcplus4", PCPlus4M, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("add_5_7", ALUResultM, 32'd12);
    chk("add_valid", 32'(ValidM), 32'h1);
    chk("add_regwrite", 32'(RegWriteM), 32'h1);

    // Side-band fields; WriteDataM takes RD2, not the immediate
    RdE = 5'd7; PCPlus4E = 32'h44; RD2E = 32'hAB; ResultSrcE = 2'b10; a_typeE = 1'b1;
    tick();
    chk("rdm", 32'(RdM), 32'd7);
    chk("pcplus4m", PCPlus4M, 32'h44);
    chk("writedata_rd2", WriteDataM, 32'hAB);
    chk("resultsrc", 32'(ResultSrcM), 32'h2);
    chk("a_type", 32'(a_typeM), 32'h1);

    // Forwarding A from ResultW, then from ALUResultM
    clr();
    alu_imm(4'b0000, 32'h40, 32'h0);
    chk("fwd_seed", ALUResultM, 32'h40);
    RD1E = 32'd1; ResultW = 32'h20; ForwardAE = 2'b01;
    ALUControlE = 4'b0001; ImmExtE = 32'h10;
    tick();
    chk("fwdA_01_sub", ALUResultM, 32'h10);
    ForwardAE = 2'b00;
    alu_imm(4'b0000, 32'h40, 32'h0);
    RD1E = 32'd1; ForwardAE = 2'b10; ALUControlE = 4'b0001; ImmExtE = 32'h10;
    tick();
    chk("fwdA_10_sub", ALUResultM, 32'h30);
    ForwardAE = 2'b11; RD1E = 32'd3;
    tick();
    chk("fwdA_11_rd1", ALUResultM, 32'hFFFFFFF3);
    ForwardAE = 2'b00; ForwardBE = 2'b01; RD2E = 32'h3; ResultW = 32'h20;
    tick();
    chk("fwdB_01_wdata", WriteDataM, 32'h20);
    ForwardBE = 2'b00;

    // Arithmetic boundaries and undefined code
    alu_imm(4'b0001, 32'h0, 32'h1);
    chk("sub_0_1", ALUResultM, 32'hFFFFFFFF);
    alu_imm(4'b1111, 32'h5, 32'h6);
    chk("undef_op", ALUResultM, 32'h0);
    alu_imm(4'b0101, 32'hFFFFFFFF, 32'h1);
    chk("slt", ALUResultM, 32'h1);
    alu_imm(4'b0110, 32'hFFFFFFFF, 32'h1);
    chk("sltu", ALUResultM, 32'h0);
    alu_imm(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00);
    chk("xor", ALUResultM, 32'h0FF00FF0);
    alu_imm(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00);
    chk("and", ALUResultM, 32'hF000F000);
    alu_imm(4'b0011, 32'hF0F0F0F0, 32'h0F00FF00);
    chk("or", ALUResultM, 32'hFFF0FFF0);
    alu_imm(4'b1010, 32'h1, 32'h12345000);
    chk("passb", ALUResultM, 32'h12345000);

    // Shifts use only SrcBE[4:0]
    alu_imm(4'b1001, 32'h80000000, 32'd4);
    chk("sra", ALUResultM, 32'hF8000000);
    alu_imm(4'b1000, 32'h80000000, 32'd4);
    chk("srl", ALUResultM, 32'h08000000);
    alu_imm(4'b0111, 32'h1, 32'h21);
    chk("sll_wrap", ALUResultM, 32'h2);

    // Branch resolution (combinational)
    clr();
    BranchE = 1'b1; Funct3E = 3'b100; RD1E = 32'hFFFFFFFF; RD2E = 32'h1;
    PCE = 32'h100; ImmExtE = 32'h20;
    #1;
    chk("blt_taken", 32'(PCSrcE), 32'h1);
    chk("blt_target", PCTargetE, 32'h120);
    Funct3E = 3'b110; #1;
    chk("bltu_not", 32'(PCSrcE), 32'h0);
    Funct3E = 3'b101; #1;
    chk("bge_not", 32'(PCSrcE), 32'h0);
    Funct3E = 3'b111; #1;
    chk("bgeu_taken", 32'(PCSrcE), 32'h1);
    Funct3E = 3'b001; #1;
    chk("bne_taken", 32'(PCSrcE), 32'h1);
    Funct3E = 3'b010; #1;
    chk("br_undef", 32'(PCSrcE), 32'h0);
    Funct3E = 3'b000; RD2E = 32'hFFFFFFFF; #1;
    chk("beq_taken", 32'(PCSrcE), 32'h1);
    ValidE = 1'b0; #1;
    chk("beq_invalid", 32'(PCSrcE), 32'h0);

    // JALR clears bit 0 of the target
    clr();
    JalrE = 1'b1; JumpE = 1'b1; RD1E = 32'h1003; ImmExtE = 32'h4; PCE = 32'h500;
    #1;
    chk("jalr_target", PCTargetE, 32'h1006);
    chk("jalr_pcsrc", 32'(PCSrcE), 32'h1);
    ValidE = 1'b0; #1;
    chk("jalr_invalid", 32'(PCSrcE), 32'h0);
    tick();

    // Stall holds M for three edges while inputs change
    clr();
    RegWriteE = 1'b1;
    alu_imm(4'b0000, 32'd4, 32'd5);
    chk("stall_seed", ALUResultM, 32'd9);
    EnM = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      RD1E = 32'(i * 100); RdE = 5'(i); ValidE = i[0];
      tick();
      chk("stall_hold", ALUResultM, 32'd9);
    end
    chk("stall_valid", 32'(ValidM), 32'h1);

    // Flush wins over enable
    EnM = 1'b1; FlushM = 1'b1; RegWriteE = 1'b1; ValidE = 1'b1;
    tick();
    chk("flush_regwrite", 32'(RegWriteM), 32'h0);
    chk("flush_valid", 32'(ValidM), 32'h0);
    chk("flush_alu", ALUResultM, 32'h0);

    // Invalid slot gates control bits
    FlushM = 1'b0; ValidE = 1'b0; RegWriteE = 1'b1; MemWriteE = 1'b1;
    alu_imm(4'b0000, 32'd1, 32'd2);
    chk("inv_regwrite", 32'(RegWriteM), 32'h0);
    chk("inv_memwrite", 32'(MemWriteM), 32'h0);
    chk("inv_validm", 32'(ValidM), 32'h0);

    // Mid-pipeline reset discards M contents; reset also beats flush
    ValidE = 1'b1;
    alu_imm(4'b0000, 32'd8, 32'd8);
    chk("pre_rst", ALUResultM, 32'd16);
    rst_n = 1'b0; FlushM = 1'b1;
    tick();
    chk("midrst_alu", ALUResultM, 32'h0);
    chk("midrst_regwrite", 32'(RegWriteM), 32'h0);
    rst_n = 1'b1; FlushM = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
